hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side companion to the EX-stage forwarding mux logic. Tracks every in-flight register
//  write from ID issue through EX, MEM and WB in a 3-slot shadow pipeline. Raises the ID-stage
//  stall on RAW hazards that forwarding cannot cover. Publishes a pending-register bitmap and a
//  stall performance counter. Sits beside the ID/EX pipeline register and drives its hold/bubble control.
// PARAMETERS
//  NREG     32  architectural register count; index width = $clog2(NREG)
//  CNT_W    32  width of the saturating stall counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous reset, active-low
//  id_valid       in   1      ID holds a real instruction
//  id_rs          in   5      ID source register A
//  id_rt          in   5      ID source register B
//  id_uses_rs     in   1      instruction reads rs
//  id_uses_rt     in   1      instruction reads rt
//  id_wr_addr     in   5      ID destination register
//  id_RegWrite    in   1      ID instruction writes a register
//  id_MemRead     in   1      ID instruction is a load
//  flush          in   1      branch mispredict: kill the instruction leaving ID
//  stall          out  1      hold PC/IF-ID, insert bubble into EX (combinational)
//  pending        out  NREG   bit r = some valid slot will write r (bit 0 always 0)
//  ex_is_load     out  1      EX slot holds a valid load
//  stall_cnt      out  CNT_W  cycles with stall && !flush, saturating
// BEHAVIOUR
//  - Slots EX, MEM, WB: each holds {v, rd[4:0], ld}. rd==0 or !RegWrite is stored as v=0.
//  - Reset (rst_n=0 at clk edge): all slots v=0, rd=0, ld=0; stall_cnt=0. Then stall=0,
//    pending=0, ex_is_load=0. Reset wins over every other input that cycle.
//  - Each edge: WB<=MEM, MEM<=EX unconditionally; there is no back-pressure past EX.
//  - EX next: bubble if flush || stall || !id_valid. Otherwise
//    {id_RegWrite && id_wr_addr!=0, id_wr_addr, id_MemRead}.
//  - Hit(s, r) = s.v && s.rd==r && r!=0. Reads qualified by id_valid && id_uses_*.
//  - Stall rule (SB_FORWARD_EN defined): stall = Hit(EX, rs|rt) && EX.ld.
//    This is the load-use case; exactly 1 bubble per load-use pair.
//  - Stall rule (SB_FORWARD_EN undefined): stall = Hit(EX|MEM, rs|rt).
//    The WB slot is excluded because the register file writes before it is read in the same cycle.
//    Dependent distance 1 gives 2 stall cycles; distance 2 gives 1.
//  - stall is purely combinational from current slots and ID inputs; no registered latency.
//  - flush && stall together: EX gets a bubble; stall output still reflects the hazard;
//    stall_cnt does not increment.
//  - stall_cnt: +1 per cycle with stall && !flush. Holds at all-ones (no wrap).
//  - pending[r] = OR over slots of Hit(slot, r). It is combinational from registered slots only.
//  - A load to r0 never stalls. A dependency on an instruction with !RegWrite never stalls.
// CONFIGURATION
//  SB_FORWARD_EN defined: the datapath has EX/MEM and MEM/WB forwarding; only load-use stalls.
//  SB_FORWARD_EN undefined: no forwarding; any match in EX or MEM stalls.
//  Ports and slot tracking are identical in both builds.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with id_valid=1 and a hazard-shaped input.
//    -> stall=0, pending=0, stall_cnt=0 after release.
//  2 FWD_EN: lw r5; add r6,r5,r1 issued back to back.
//    -> stall=1 exactly 1 cycle, stall_cnt=1, pending[5]=1 for 3 cycles.
//  3 FWD_EN: add r5; sub r7,r5,r2.
//    -> stall=0 throughout.
//    !FWD_EN same pair -> stall=1 for 2 cycles, then sub issues; stall_cnt=2.
//  4 lw r0; add r3,r0,r0.
//    -> stall=0, pending=0.
//    lw r8 then add r9,r8 with flush=1 in the stall cycle
//    -> EX bubble, stall_cnt unchanged.
//  5 Hold a load-use hazard for 2^CNT_W+3 cycles (use CNT_W=4).
//    -> stall_cnt saturates at 15.
//    Then assert rst_n=0 mid-stall -> stall=0 and slots cleared on the next edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: 3-slot EX/MEM/WB shadow of in-flight register writes, combinational ID stall, pending bitmap, saturating stall counter.
// Optional SB_FORWARD_EN: when defined only load-use stalls, otherwise any EX/MEM match stalls; no back-pressure past EX.
module hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [$clog2(NREG)-1:0] id_rs,
  input  logic [$clog2(NREG)-1:0] id_rt,
  input  logic                    id_uses_rs,
  input  logic                    id_uses_rt,
  input  logic [$clog2(NREG)-1:0] id_wr_addr,
  input  logic                    id_RegWrite,
  input  logic                    id_MemRead,
  input  logic                    flush,
  output logic                    stall,
  output logic [NREG-1:0]         pending,
  output logic                    ex_is_load,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int IDX_W = $clog2(NREG);

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] rd;
    logic             ld;
  } slot_t;

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  slot_t            w_ex_nxt;
  logic             w_rd_rs;
  logic             w_rd_rt;
  logic             w_hit_ex;
  logic             w_stall;
  logic [NREG-1:0]  w_pending;
  logic             w_unused_wb_ld;

  function automatic logic hit(input slot_t s, input logic [IDX_W-1:0] r);
    return s.v && (s.rd == r) && (r != '0);
  endfunction

  assign w_rd_rs  = id_valid && id_uses_rs;
  assign w_rd_rt  = id_valid && id_uses_rt;
  assign w_hit_ex = (w_rd_rs && hit(r_ex, id_rs)) || (w_rd_rt && hit(r_ex, id_rt));

`ifdef SB_FORWARD_EN
  // Forwarding covers everything except a load whose data is not ready until MEM.
  assign w_stall = w_hit_ex && r_ex.ld;
`else
  logic w_hit_mem;
  assign w_hit_mem = (w_rd_rs && hit(r_mem, id_rs)) || (w_rd_rt && hit(r_mem, id_rt));
  // WB is excluded: the register file writes in the first half-cycle, reads in the second.
  assign w_stall   = w_hit_ex || w_hit_mem;
`endif

  always_comb begin
    w_ex_nxt = '0;
    if (id_valid && !flush && !w_stall) begin
      w_ex_nxt.v  = id_RegWrite && (id_wr_addr != '0);
      w_ex_nxt.rd = id_wr_addr;
      w_ex_nxt.ld = id_MemRead;
    end
  end

  always_comb begin
    w_pending = '0;
    for (int r = 1; r < NREG; r++) begin
      w_pending[r] = hit(r_ex, IDX_W'(r)) || hit(r_mem, IDX_W'(r)) || hit(r_wb, IDX_W'(r));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_ex  <= w_ex_nxt;
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_stall && !flush && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // The WB load flag is carried for slot uniformity but nothing downstream needs it.
  assign w_unused_wb_ld = r_wb.ld;

  assign stall      = w_stall;
  assign pending    = w_pending;
  assign ex_is_load = r_ex.v && r_ex.ld;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expectations queued per driven cycle, popped and checked at the falling edge.
// Expected sequences for the SB_FORWARD_EN and default builds are selected by the same macro.
module tb_hazard_scoreboard;

  localparam int NREG  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_wr_addr;
  logic             id_RegWrite;
  logic             id_MemRead;
  logic             flush;
  logic             stall;
  logic [NREG-1:0]  pending;
  logic             ex_is_load;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_wr_addr (id_wr_addr),
    .id_RegWrite(id_RegWrite),
    .id_MemRead (id_MemRead),
    .flush      (flush),
    .stall      (stall),
    .pending    (pending),
    .ex_is_load (ex_is_load),
    .stall_cnt  (stall_cnt)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] wr;
    logic       rw;
    logic       mr;
  } id_t;

  typedef struct {
    string       tag;
    logic        st;
    logic [31:0] pend;
    logic        exld;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam id_t IDLE = '0;

  function automatic id_t ins(int wr, logic rw, logic mr, int rs, logic urs, int rt, logic urt);
    id_t i;
    i.v   = 1'b1;
    i.wr  = 5'(wr);
    i.rw  = rw;
    i.mr  = mr;
    i.rs  = 5'(rs);
    i.urs = urs;
    i.rt  = 5'(rt);
    i.urt = urt;
    return i;
  endfunction

  function automatic logic [31:0] bit_of(int r);
    logic [31:0] m;
    m = '0;
    m[r] = 1'b1;
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(id_t i, logic fl);
    id_valid    = i.v;
    id_rs       = i.rs;
    id_rt       = i.rt;
    id_uses_rs  = i.urs;
    id_uses_rt  = i.urt;
    id_wr_addr  = i.wr;
    id_RegWrite = i.rw;
    id_MemRead  = i.mr;
    flush       = fl;
  endtask

  // Drive one cycle of ID inputs, queue what the outputs must be in that cycle, then check them.
  task automatic step(string tag, id_t i, logic fl, logic st, logic [31:0] pend, logic exld, int cnt);
    exp_t e;
    exp_t o;
    drive(i, fl);
    e.tag  = tag;
    e.st   = st;
    e.pend = pend;
    e.exld = exld;
    e.cnt  = 32'(cnt);
    q.push_back(e);
    @(negedge clk);
    o = q.pop_front();
    chk({o.tag, ".stall"},      32'(stall),      32'(o.st));
    chk({o.tag, ".pending"},    pending,         o.pend);
    chk({o.tag, ".ex_is_load"}, 32'(ex_is_load), 32'(o.exld));
    chk({o.tag, ".stall_cnt"},  32'(stall_cnt),  o.cnt);
    @(posedge clk);
    #1;
  endtask

  // Two reset edges with a hazard-shaped instruction in ID, then release.
  task automatic do_reset(string tag);
    id_t hz;
    hz = ins(6, 1'b1, 1'b1, 5, 1'b1, 5, 1'b1);
    rst_n = 1'b0;
    drive(hz, 1'b0);
    @(posedge clk);
    #1;
    step({tag, "_hold"}, hz, 1'b0, 1'b0, '0, 1'b0, 0);
    rst_n = 1'b1;
    step({tag, "_rel"}, IDLE, 1'b0, 1'b0, '0, 1'b0, 0);
  endtask

  initial begin
    id_t lw5, add6, add5, sub7, lw0, add3, nw9, rd9, lw8, add9, lw8s;
    logic st_k, ld_k;
    int   nst;

    lw5  = ins(5, 1, 1, 1, 1, 0, 0);
    add6 = ins(6, 1, 0, 5, 1, 1, 1);
    add5 = ins(5, 1, 0, 1, 1, 2, 1);
    sub7 = ins(7, 1, 0, 5, 1, 2, 1);
    lw0  = ins(0, 1, 1, 1, 1, 0, 0);
    add3 = ins(3, 1, 0, 0, 1, 0, 1);
    nw9  = ins(9, 0, 1, 1, 1, 0, 0);
    rd9  = ins(10, 1, 0, 9, 1, 9, 1);
    lw8  = ins(8, 1, 1, 1, 1, 0, 0);
    add9 = ins(9, 1, 0, 8, 1, 1, 1);
    lw8s = ins(8, 1, 1, 8, 1, 0, 0);

    rst_n = 1'b0;
    drive(IDLE, 1'b0);
    do_reset("rst");

    // Load-use: lw r5 ; add r6,r5,r1
`ifdef SB_FORWARD_EN
    step("lu0", lw5,  0, 0, '0,                     0, 0);
    step("lu1", add6, 0, 1, bit_of(5),              1, 0);
    step("lu2", add6, 0, 0, bit_of(5),              0, 1);
    step("lu3", IDLE, 0, 0, bit_of(5) | bit_of(6),  0, 1);
    step("lu4", IDLE, 0, 0, bit_of(6),              0, 1);
    step("lu5", IDLE, 0, 0, bit_of(6),              0, 1);
    step("lu6", IDLE, 0, 0, '0,                     0, 1);
`else
    step("lu0", lw5,  0, 0, '0,        0, 0);
    step("lu1", add6, 0, 1, bit_of(5), 1, 0);
    step("lu2", add6, 0, 1, bit_of(5), 0, 1);
    step("lu3", add6, 0, 0, bit_of(5), 0, 2);
    step("lu4", IDLE, 0, 0, bit_of(6), 0, 2);
    step("lu5", IDLE, 0, 0, bit_of(6), 0, 2);
    step("lu6", IDLE, 0, 0, bit_of(6), 0, 2);
    step("lu7", IDLE, 0, 0, '0,        0, 2);
`endif

    // ALU dependency: add r5 ; sub r7,r5,r2
    do_reset("rst2");
`ifdef SB_FORWARD_EN
    step("alu0", add5, 0, 0, '0,                    0, 0);
    step("alu1", sub7, 0, 0, bit_of(5),             0, 0);
    step("alu2", IDLE, 0, 0, bit_of(5) | bit_of(7), 0, 0);
    step("alu3", IDLE, 0, 0, bit_of(5) | bit_of(7), 0, 0);
    step("alu4", IDLE, 0, 0, bit_of(7),             0, 0);
`else
    step("alu0", add5, 0, 0, '0,        0, 0);
    step("alu1", sub7, 0, 1, bit_of(5), 0, 0);
    step("alu2", sub7, 0, 1, bit_of(5), 0, 1);
    step("alu3", sub7, 0, 0, bit_of(5), 0, 2);
    step("alu4", IDLE, 0, 0, bit_of(7), 0, 2);
`endif

    // r0 writes, non-writing producer, and flush during a load-use stall
    do_reset("rst3");
    step("r0_0",  lw0,  0, 0, '0,                     0, 0);
    step("r0_1",  add3, 0, 0, '0,                     0, 0);
    step("r0_2",  IDLE, 0, 0, bit_of(3),              0, 0);
    step("nw_0",  nw9,  0, 0, bit_of(3),              0, 0);
    step("nw_1",  rd9,  0, 0, bit_of(3),              0, 0);
    step("nw_2",  IDLE, 0, 0, bit_of(10),             0, 0);
    step("fl_0",  lw8,  0, 0, bit_of(10),             0, 0);
    step("fl_1",  add9, 1, 1, bit_of(8) | bit_of(10), 1, 0);
    step("fl_2",  IDLE, 0, 0, bit_of(8),              0, 0);
    step("fl_3",  IDLE, 0, 0, bit_of(8),              0, 0);
    step("fl_4",  IDLE, 0, 0, '0,                     0, 0);

    // Self-dependent load held in ID: stall pattern repeats, counter must saturate.
    do_reset("rst4");
    nst = 0;
    for (int k = 0; k < 42; k++) begin
`ifdef SB_FORWARD_EN
      st_k = (k % 2) == 1;
      ld_k = (k % 2) == 1;
`else
      st_k = (k % 3) != 0;
      ld_k = (k % 3) == 1;
`endif
      // Last iteration asserts reset while the hazard is live.
      if (k == 41) rst_n = 1'b0;
      step($sformatf("sat%0d", k), lw8s, 0, st_k, (k == 0) ? 32'd0 : bit_of(8), ld_k,
           (nst > 15) ? 15 : nst);
      if (st_k) nst++;
    end
    rst_n = 1'b1;
    step("post_rst0", lw8s, 0, 0, '0,        0, 0);
    step("post_rst1", lw8s, 0, 1, bit_of(8), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
